// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                             |
// | Description : Raster timing generator for a VGA-style display. Keeps a   |
// |               horizontal/vertical pixel position that advances on pixel  |
// |               enable cycles and derives sync, visible-region and         |
// |               line/frame start strobes aligned to that position.         |
// | Ports       : vga_clk     - sole clock, rising edge                      |
// |               reset       - synchronous, active-high                     |
// |               pix_en      - pixel advance enable                         |
// |               DrawX/DrawY - current horizontal / vertical position       |
// |               hs/vs       - horizontal / vertical sync, active low       |
// |               blank       - 1 inside the visible region                  |
// |               line_start  - one-clock strobe when DrawX becomes 0        |
// |               frame_start - one-clock strobe when position wraps to 0,0  |
// |               frame_count - completed frames, modulo 256                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       pix_en,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] c_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] r_draw_x;
   logic [9:0] r_draw_y;
   logic       r_hs;
   logic       r_vs;
   logic       r_blank;
   logic       r_line_start;
   logic       r_frame_start;
   logic [7:0] r_frame_count;

   logic       w_x_wrap;
   logic       w_y_wrap;
   logic [9:0] w_next_x;
   logic [9:0] w_next_y;
   logic       w_next_hs;
   logic       w_next_vs;
   logic       w_next_blank;

   // Wrap on ">=" so an out-of-range position can never persist.
   assign w_x_wrap = (r_draw_x >= c_H_LAST);
   assign w_y_wrap = (r_draw_y >= c_V_LAST);

   always_comb begin
      w_next_x = r_draw_x + 10'd1;
      w_next_y = r_draw_y;
      if (w_x_wrap) begin
         w_next_x = 10'd0;
         w_next_y = w_y_wrap ? 10'd0 : (r_draw_y + 10'd1);
      end
   end

   // Sync and visible-region flags are decoded from the position about to be
   // loaded, so once registered they line up with DrawX/DrawY on the same
   // cycle instead of trailing them by one clock.
   assign w_next_hs    = ~((w_next_x >= c_HS_START) && (w_next_x < c_HS_END));
   assign w_next_vs    = ~((w_next_y >= c_VS_START) && (w_next_y < c_VS_END));
   assign w_next_blank = (w_next_x < c_H_VIS) && (w_next_y < c_V_VIS);

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_draw_x      <= 10'd0;
         r_draw_y      <= 10'd0;
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_blank       <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         // Strobes last a single clock even when the next cycle is stalled.
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         if (pix_en) begin
            r_draw_x      <= w_next_x;
            r_draw_y      <= w_next_y;
            r_hs          <= w_next_hs;
            r_vs          <= w_next_vs;
            r_blank       <= w_next_blank;
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_x_wrap & w_y_wrap;
            if (w_x_wrap && w_y_wrap) begin
               r_frame_count <= r_frame_count + 8'd1;
            end
         end
      end
   end

   assign DrawX       = r_draw_x;
   assign DrawY       = r_draw_y;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign blank       = r_blank;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                          |
// | Description : Self-checking bench for vga_timing_gen. A reduced-size     |
// |               instance (index 0) allows many whole frames; a default     |
// |               640x480 instance (index 1) runs alongside it. Both are     |
// |               checked each cycle against a linear pixel-index model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

   localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
   localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;
   logic pix_en  = 1'b0;

   logic [9:0] dx_s, dy_s, dx_d, dy_d;
   logic       hs_s, vs_s, bl_s, ls_s, fs_s;
   logic       hs_d, vs_d, bl_d, ls_d, fs_d;
   logic [7:0] fc_s, fc_d;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
   ) dut_s (
      .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
      .DrawX(dx_s), .DrawY(dy_s), .hs(hs_s), .vs(vs_s), .blank(bl_s),
      .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
   );

   vga_timing_gen dut_d (
      .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
      .DrawX(dx_d), .DrawY(dy_d), .hs(hs_d), .vs(vs_d), .blank(bl_d),
      .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: position is a single pixel index within the frame.
   int hv[2], hf[2], hsy[2], ht[2], vv[2], vf[2], vsy[2], vt[2];
   int pos[2], frames[2];
   bit fresh[2], ls_e[2], fs_e[2];

   task automatic model_update(input bit r, input bit e);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            pos[i] = 0; frames[i] = 0; fresh[i] = 1'b1;
            ls_e[i] = 1'b0; fs_e[i] = 1'b0;
         end else if (e) begin
            pos[i]   = (pos[i] + 1) % (ht[i] * vt[i]);
            fresh[i] = 1'b0;
            ls_e[i]  = (pos[i] % ht[i]) == 0;
            fs_e[i]  = (pos[i] == 0);
            if (fs_e[i]) frames[i] = (frames[i] + 1) % 256;
         end else begin
            ls_e[i] = 1'b0; fs_e[i] = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      int x, y, ehs, evs, ebl;
      for (int i = 0; i < 2; i++) begin
         x   = pos[i] % ht[i];
         y   = pos[i] / ht[i];
         ehs = (x >= hv[i] + hf[i] && x < hv[i] + hf[i] + hsy[i]) ? 0 : 1;
         evs = (y >= vv[i] + vf[i] && y < vv[i] + vf[i] + vsy[i]) ? 0 : 1;
         ebl = (!fresh[i] && x < hv[i] && y < vv[i]) ? 1 : 0;
         if (i == 0) begin
            check_val("s_DrawX", int'(dx_s), x);
            check_val("s_DrawY", int'(dy_s), y);
            check_val("s_hs", int'(hs_s), ehs);
            check_val("s_vs", int'(vs_s), evs);
            check_val("s_blank", int'(bl_s), ebl);
            check_val("s_line_start", int'(ls_s), int'(ls_e[0]));
            check_val("s_frame_start", int'(fs_s), int'(fs_e[0]));
            check_val("s_frame_count", int'(fc_s), frames[0]);
         end else begin
            check_val("d_DrawX", int'(dx_d), x);
            check_val("d_DrawY", int'(dy_d), y);
            check_val("d_hs", int'(hs_d), ehs);
            check_val("d_vs", int'(vs_d), evs);
            check_val("d_blank", int'(bl_d), ebl);
            check_val("d_line_start", int'(ls_d), int'(ls_e[1]));
            check_val("d_frame_start", int'(fs_d), int'(fs_e[1]));
            check_val("d_frame_count", int'(fc_d), frames[1]);
         end
      end
   endtask

   // Called at a falling edge: drive inputs, predict, sample next falling edge.
   task automatic step(input bit r, input bit e);
      reset  = r;
      pix_en = e;
      model_update(r, e);
      @(negedge vga_clk);
      compare_all();
   endtask

   initial begin
      int hs_low, ls_cnt, bl_cnt, fs_cnt;
      hv[0] = S_HV; hf[0] = S_HF; hsy[0] = S_HS; vv[0] = S_VV; vf[0] = S_VF; vsy[0] = S_VS;
      ht[0] = S_HV + S_HF + S_HS + S_HB; vt[0] = S_VV + S_VF + S_VS + S_VB;
      hv[1] = 640; hf[1] = 16; hsy[1] = 96; vv[1] = 480; vf[1] = 10; vsy[1] = 2;
      ht[1] = 800; vt[1] = 525;

      @(negedge vga_clk);
      step(1'b1, 1'b1);               // reset wins over pix_en
      step(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0);  // stalled: (0,0) stays blanked

      // Two default-size lines with continuous enable.
      hs_low = 0; ls_cnt = 0;
      for (int k = 0; k < 1600; k++) begin
         step(1'b0, 1'b1);
         if (k < 800) begin
            if (!hs_d) hs_low++;
            if (ls_d) ls_cnt++;
         end
      end
      check_val("d_hs_low_per_line", hs_low, 96);
      check_val("d_line_start_per_line", ls_cnt, 1);

      // Random enable with occasional mid-frame reset.
      for (int k = 0; k < 3000; k++)
         step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);

      // Alternating enable: one default line spans 1600 clocks.
      ls_cnt = 0;
      for (int k = 0; k < 1600; k++) begin
         step(1'b0, (k % 2) == 0);
         if (ls_d) ls_cnt++;
      end
      check_val("d_line_start_alt", ls_cnt, 1);

      // 256 small frames from reset: frame_count wraps back to 0.
      step(1'b1, 1'b0);
      bl_cnt = 0; fs_cnt = 0;
      for (int k = 1; k <= 256 * ht[0] * vt[0]; k++) begin
         step(1'b0, 1'b1);
         if (fs_s) fs_cnt++;
         if (k >= ht[0] * vt[0] && k < 2 * ht[0] * vt[0] && bl_s) bl_cnt++;
      end
      check_val("s_blank_per_frame", bl_cnt, S_HV * S_VV);
      check_val("s_frame_starts", fs_cnt, 256);
      check_val("s_frame_count_wrap", int'(fc_s), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch; line total H_TOTAL = 800.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameters V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33; frame total V_TOTAL = 525.
REQ-007 SHALL have port vga_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port pix_en, input, 1, pixel advance enable; counters move only when high.
REQ-010 SHALL have port DrawX, output, 10, current horizontal counter value 0..H_TOTAL-1.
REQ-011 SHALL have port DrawY, output, 10, current vertical counter value 0..V_TOTAL-1.
REQ-012 SHALL have port hs, output, 1, horizontal sync, active low.
REQ-013 SHALL have port vs, output, 1, vertical sync, active low.
REQ-014 SHALL have port blank, output, 1, 1 = visible region (pixel may be driven), 0 = blanking.
REQ-015 SHALL have ports line_start and frame_start, output, 1 each, single-clock pulses.
REQ-016 SHALL have port frame_count, output, 8, count of completed frames.

Function
REQ-017 SHALL hold all counters and outputs unchanged on any clock where pix_en = 0.
REQ-018 SHALL, on a pix_en cycle, increment DrawX; at DrawX = H_TOTAL-1 it wraps to 0 and DrawY increments.
REQ-019 SHALL wrap DrawY from V_TOTAL-1 to 0 on the same cycle DrawX wraps (frame wrap).
REQ-020 SHALL register hs, vs, blank so each reflects the (DrawX, DrawY) value presented on the same cycle (zero relative latency).
REQ-021 SHALL drive hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 default).
REQ-022 SHALL drive vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 default), independent of DrawX.
REQ-023 SHALL drive blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-024 SHALL pulse line_start high for exactly one vga_clk cycle, the pix_en cycle on which DrawX becomes 0; low otherwise, including stalled cycles.
REQ-025 SHALL pulse frame_start high for one cycle when (DrawX, DrawY) becomes (0,0) via wrap; line_start also pulses that cycle.
REQ-026 SHALL increment frame_count with frame_start, wrapping 255 -> 0.
REQ-027 SHALL never produce DrawX >= H_TOTAL or DrawY >= V_TOTAL.

Reset
REQ-028 SHALL, on a clock with reset = 1, set DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, line_start = 0, frame_start = 0, frame_count = 0, regardless of pix_en.
REQ-029 SHALL keep blank = 0 after reset release until the first pix_en cycle, then follow REQ-023 (pixel (0,0) of the first post-reset frame is blanked).
REQ-030 SHALL treat reset asserted mid-frame identically; no pulse on line_start/frame_start for the reset-induced return to (0,0).
REQ-031 SHALL give reset priority over pix_en on the same cycle.

Verification
REQ-032 SHALL pass: reset 2 cycles, pix_en = 1 for 800 cycles -> DrawX 1..799 then 0, DrawY 0 -> 1, line_start high only on the wrap cycle, hs low for exactly 96 consecutive cycles at DrawX 656..751.
REQ-033 SHALL pass: pix_en = 1 for 420000 cycles (one frame) -> exactly one frame_start at (0,0), frame_count 0 -> 1, vs low for exactly 1600 cycles (DrawY 490..491).
REQ-034 SHALL pass: blank count over one full frame = 307200 (640x480), blank = 0 at (640,0) and (0,480).
REQ-035 SHALL pass: pix_en toggled 1/0 alternately -> counters advance every other clock, one full line takes 1600 clocks, line_start width stays one clock.
REQ-036 SHALL pass: reset asserted at DrawX = 700, DrawY = 300 with pix_en = 1 -> next cycle DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 0, frame_start = 0, frame_count = 0.
REQ-037 SHALL pass: run 256 frames -> frame_count wraps 255 -> 0 on the 256th frame_start.
